// File: rtl/lcd_text_arbiter_if.sv
// Write-request bundle shared by the two LCD text buffer requesters (CPU MMIO, debug writer).
// The master side drives valid/index/char and the slave side returns ready.
interface lcd_text_arbiter_if;
    logic       req0_valid;
    logic [4:0] req0_index;
    logic [7:0] req0_char;
    logic       req0_ready;
    logic       req1_valid;
    logic [4:0] req1_index;
    logic [7:0] req1_char;
    logic       req1_ready;

    modport master (
        output req0_valid, req0_index, req0_char,
        output req1_valid, req1_index, req1_char,
        input  req0_ready, req1_ready
    );

    modport slave (
        input  req0_valid, req0_index, req0_char,
        input  req1_valid, req1_index, req1_char,
        output req0_ready, req1_ready
    );
endinterface

// File: rtl/lcd_text_arbiter.sv
// 32x8 LCD text buffer with round-robin write arbitration between two requesters.
// Define LCD_ARB_CLEAR_EN to compile in the full-screen blanking sequencer (clear_req/clear_busy).
module lcd_text_arbiter (
    input  logic               clk,
    input  logic               reset,
    lcd_text_arbiter_if.slave  req,
    input  logic               clear_req,
    output logic               clear_busy,
    input  logic [4:0]         lcd_index,
    output logic [7:0]         lcd_char,
    output logic [15:0]        wr_count
);
    localparam logic [7:0] SPACE = 8'h20;

    logic [7:0]  cells_q [32];
    logic        last_q;         // 1: port 1 won the most recent grant
    logic [15:0] wr_count_q;
    logic [7:0]  lcd_char_q;

    logic        arb_en;
    logic        grant0;
    logic        grant1;
    logic        wr_en;
    logic [4:0]  wr_index;
    logic [7:0]  wr_char;

`ifdef LCD_ARB_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic        clear_busy_q;

    // The clear_req cycle itself issues no grant; blanking starts on the next cycle.
    assign arb_en = (state_q == IDLE) && !clear_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 5'd0;
            clear_busy_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q      <= CLEAR;
                        cnt_q        <= 5'd0;
                        clear_busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q      <= IDLE;
                        clear_busy_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign clear_busy = clear_busy_q;
`else
    wire unused_clear_req = clear_req;

    assign arb_en     = 1'b1;
    assign clear_busy = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb_en) begin
            if (req.req0_valid && (!req.req1_valid || last_q)) begin
                grant0 = 1'b1;
            end else if (req.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req.req0_ready = grant0;
    assign req.req1_ready = grant1;

    always_comb begin
        wr_en    = grant0 | grant1;
        wr_index = grant0 ? req.req0_index : req.req1_index;
        wr_char  = grant0 ? req.req0_char  : req.req1_char;
`ifdef LCD_ARB_CLEAR_EN
        if (state_q == CLEAR) begin
            wr_en    = 1'b1;
            wr_index = cnt_q;
            wr_char  = SPACE;
        end
`endif
    end

    // NOTE: the buffer is built from flops and every cell is reset to a space, so it cannot map onto a RAM macro.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                cells_q[i] <= SPACE;
            end
            last_q     <= 1'b1;
            wr_count_q <= 16'd0;
            lcd_char_q <= SPACE;
        end else begin
            // NOTE: non-blocking assignments make the read sample the pre-write contents on a same-cell collision.
            lcd_char_q <= cells_q[lcd_index];
            if (wr_en) begin
                cells_q[wr_index] <= wr_char;
            end
            if (grant0 || grant1) begin
                last_q     <= grant1;
                wr_count_q <= wr_count_q + 16'd1;
            end
        end
    end

    assign lcd_char = lcd_char_q;
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_lcd_text_arbiter.sv
// Self-checking bench for lcd_text_arbiter: directed steps plus randomized traffic against a
// behavioural model of the text buffer; the blanking checks follow LCD_ARB_CLEAR_EN.
module tb_lcd_text_arbiter;
    logic        clk;
    logic        reset;
    logic        clear_req;
    logic        clear_busy;
    logic [4:0]  lcd_index;
    logic [7:0]  lcd_char;
    logic [15:0] wr_count;

    lcd_text_arbiter_if bus ();

    lcd_text_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req        (bus),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .lcd_index  (lcd_index),
        .lcd_char   (lcd_char),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: screen contents, last winner, total accepted writes, cells still to blank.
    logic [7:0] mem_m [32];
    bit         last_m;
    int         wr_m;
    int         clear_left;

    int n_cmp;
    int n_err;
    bit g0_seen;
    bit g1_seen;
    bit obs_r0;
    bit obs_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = 8'h20;
        last_m     = 1'b1;
        wr_m       = 0;
        clear_left = 0;
    endtask

    task automatic do_reset(input int cycles);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        clear_req      = 1'b0;
        reset          = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        model_reset();
        check("rst/lcd_char", lcd_char, 8'h20);
        check("rst/ready0", bus.req0_ready, 1'b0);
        check("rst/ready1", bus.req1_ready, 1'b0);
        check("rst/clear_busy", clear_busy, 1'b0);
        check("rst/wr_count", wr_count, 16'h0000);
        reset = 1'b0;
    endtask

    // One clock: inputs are already driven; check grants mid-cycle, then registered outputs after the edge.
    task automatic do_cycle(input string tag);
        bit         e0;
        bit         e1;
        bit         busy_m;
        bit         clr_start;
        logic [7:0] exp_char;
        #3;
        e0        = 1'b0;
        e1        = 1'b0;
        busy_m    = (clear_left > 0);
        clr_start = 1'b0;
`ifdef LCD_ARB_CLEAR_EN
        clr_start = clear_req && !busy_m;
`endif
        if (!busy_m && !clr_start) begin
            if (bus.req0_valid && bus.req1_valid) begin
                e0 = (last_m == 1'b1);
                e1 = !e0;
            end else begin
                e0 = bus.req0_valid;
                e1 = bus.req1_valid;
            end
        end
        obs_r0   = bus.req0_ready;
        obs_busy = clear_busy;
        check({tag, "/ready0"}, bus.req0_ready, e0);
        check({tag, "/ready1"}, bus.req1_ready, e1);
        check({tag, "/clear_busy"}, clear_busy, busy_m);
        exp_char = mem_m[lcd_index];
        @(posedge clk);
        #1;
        if (busy_m) begin
            mem_m[32 - clear_left] = 8'h20;
            clear_left--;
        end else if (clr_start) begin
            clear_left = 32;
        end
        if (e0) begin
            mem_m[bus.req0_index] = bus.req0_char;
            last_m = 1'b0;
            wr_m++;
        end
        if (e1) begin
            mem_m[bus.req1_index] = bus.req1_char;
            last_m = 1'b1;
            wr_m++;
        end
        g0_seen = e0;
        g1_seen = e1;
        check({tag, "/lcd_char"}, lcd_char, exp_char);
        check({tag, "/wr_count"}, wr_count, wr_m % 65536);
    endtask

    task automatic sweep(input string tag, input bit expect_space);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        clear_req      = 1'b0;
        for (int i = 0; i < 32; i++) begin
            lcd_index = 5'(i);
            do_cycle(tag);
            if (expect_space) check({tag, "/space"}, lcd_char, 8'h20);
        end
    endtask

    initial begin
        int ready_low;
        int busy_cnt;
        clk            = 1'b0;
        reset          = 1'b1;
        clear_req      = 1'b0;
        lcd_index      = 5'd0;
        bus.req0_valid = 1'b0;
        bus.req0_index = 5'd0;
        bus.req0_char  = 8'h00;
        bus.req1_valid = 1'b0;
        bus.req1_index = 5'd0;
        bus.req1_char  = 8'h00;
        n_cmp          = 0;
        n_err          = 0;
        model_reset();

        do_reset(3);
        sweep("init_sweep", 1'b1);

        // Single writer: same-cycle grant, old value on the accepting edge, new value one edge later.
        bus.req0_valid = 1'b1;
        bus.req0_index = 5'd5;
        bus.req0_char  = 8'h41;
        lcd_index      = 5'd5;
        do_cycle("single_accept");
        check("single/ready_now", obs_r0, 1'b1);
        bus.req0_valid = 1'b0;
        do_cycle("single_read1");
        check("single/char_after", lcd_char, 8'h41);
        check("single/wr_count", wr_count, 16'd1);

        // Contention from reset: grants alternate starting with port 0.
        do_reset(2);
        bus.req0_valid = 1'b1;
        bus.req0_index = 5'd0;
        bus.req0_char  = 8'h61;
        bus.req1_valid = 1'b1;
        bus.req1_index = 5'd16;
        bus.req1_char  = 8'h62;
        for (int k = 0; k < 4; k++) begin
            do_cycle("rr");
            check("rr/order", obs_r0, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("rr/wr_count", wr_count, 16'd4);
        lcd_index = 5'd0;
        do_cycle("rr_rd0");
        check("rr/cell0", lcd_char, 8'h61);
        lcd_index = 5'd16;
        do_cycle("rr_rd16");
        check("rr/cell16", lcd_char, 8'h62);

`ifdef LCD_ARB_CLEAR_EN
        // Fill with 'X', then blank while port 0 is waiting.
        bus.req0_valid = 1'b1;
        bus.req0_char  = 8'h58;
        for (int i = 0; i < 32; i++) begin
            bus.req0_index = 5'(i);
            do_cycle("fill");
        end
        bus.req0_index = 5'd31;
        bus.req0_char  = 8'h5A;
        clear_req      = 1'b1;
        ready_low      = 0;
        busy_cnt       = 0;
        for (int n = 0; n < 40 && !g0_seen; n++) begin
            do_cycle("clear");
            clear_req = 1'b0;
            if (!obs_r0) ready_low++;
            if (obs_busy) busy_cnt++;
        end
        check("clear/granted", g0_seen, 1'b1);
        check("clear/ready_low_cycles", ready_low, 33);
        check("clear/busy_cycles", busy_cnt, 32);
        bus.req0_valid = 1'b0;
        for (int i = 0; i < 31; i++) begin
            lcd_index = 5'(i);
            do_cycle("clear_sweep");
            check("clear_sweep/space", lcd_char, 8'h20);
        end
        lcd_index = 5'd31;
        do_cycle("clear_last");
        check("clear/post_grant_cell", lcd_char, 8'h5A);

        // Reset on the 10th blanking cycle aborts the sequence.
        clear_req = 1'b1;
        do_cycle("abort_pulse");
        clear_req = 1'b0;
        for (int i = 0; i < 9; i++) do_cycle("abort_run");
        check("abort/busy_before", obs_busy, 1'b1);
        do_reset(1);
        sweep("abort_sweep", 1'b1);
`else
        // Blanking is compiled out: clear_req must not block a grant.
        bus.req0_valid = 1'b1;
        bus.req0_index = 5'd7;
        bus.req0_char  = 8'h37;
        clear_req      = 1'b1;
        do_cycle("noclear");
        check("noclear/ready0", obs_r0, 1'b1);
        check("noclear/busy", obs_busy, 1'b0);
        clear_req      = 1'b0;
        bus.req0_valid = 1'b0;
        do_cycle("noclear_idle");
        check("noclear/busy_after", clear_busy, 1'b0);
`endif

        // Randomized traffic honouring the hold-until-ready rule, with occasional withdrawals.
        g0_seen = 1'b0;
        g1_seen = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!bus.req0_valid || g0_seen) begin
                bus.req0_valid = ($urandom_range(0, 2) != 0);
                bus.req0_index = 5'($urandom_range(0, 31));
                bus.req0_char  = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 7) == 0) begin
                bus.req0_valid = 1'b0;
            end
            if (!bus.req1_valid || g1_seen) begin
                bus.req1_valid = ($urandom_range(0, 2) != 0);
                bus.req1_index = 5'($urandom_range(0, 31));
                bus.req1_char  = 8'($urandom_range(0, 255));
            end else if ($urandom_range(0, 7) == 0) begin
                bus.req1_valid = 1'b0;
            end
            clear_req = ($urandom_range(0, 39) == 0);
            lcd_index = 5'($urandom_range(0, 31));
            do_cycle("rand");
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        clear_req      = 1'b0;
        for (int i = 0; i < 33; i++) do_cycle("drain");
        sweep("rand_sweep", 1'b0);

        // Write counter wrap.
        do_reset(1);
        bus.req0_valid = 1'b1;
        bus.req0_index = 5'd3;
        bus.req0_char  = 8'h33;
        repeat (65535) @(posedge clk);
        #1;
        mem_m[3] = 8'h33;
        last_m   = 1'b0;
        wr_m     = 65535;
        check("wrap/ffff", wr_count, 16'hFFFF);
        do_cycle("wrap_last");
        check("wrap/zero", wr_count, 16'h0000);
        bus.req0_valid = 1'b0;
        lcd_index      = 5'd3;
        do_cycle("wrap_read");
        check("wrap/cell3", lcd_char, 8'h33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_text_arbiter.md
# lcd_text_arbiter

Owns the 32-character text buffer behind the DE2 LCD controller and shares write access between two requesters: CPU memory-mapped I/O (port 0) and a debug/status writer (port 1). The LCD controller scans `lcd_index` and reads the character back through `lcd_char`. Writes are arbitrated round-robin, one per cycle. An optional sequencer blanks the whole screen.

## Interface
- No parameters; buffer depth is fixed at 32 entries (2 lines × 16 characters) × 8 bits.
- `clk` in 1: system clock (CLOCK_50 domain).
- `reset` in 1: synchronous, active-high.
- `req0_valid` in 1: port 0 has a write pending.
- `req0_index` in 5: port 0 target cell (0–15 line 1, 16–31 line 2).
- `req0_char` in 8: port 0 ASCII character.
- `req0_ready` out 1: port 0 write accepted this cycle.
- `req1_valid`, `req1_index`, `req1_char`, `req1_ready`: same as port 0, for port 1.
- `clear_req` in 1: start a full-screen blank; effective only with the macro defined.
- `clear_busy` out 1: clear sequence in progress.
- `lcd_index` in 5: cell address from the LCD controller.
- `lcd_char` out 8: registered buffer contents at `lcd_index`.
- `wr_count` out 16: count of accepted requester writes; wraps 0xFFFF→0x0000.

## Operation
- Buffer storage is flops. On reset, all 32 cells are 0x20 (space).
- Reset values of outputs:
  - `lcd_char` = 0x20
  - `req0_ready` = 0, `req1_ready` = 0
  - `clear_busy` = 0
  - `wr_count` = 0
- Round-robin pointer `last` resets to 1, so port 0 wins the first tie.
- FSM has two states, IDLE and CLEAR.
- IDLE behaviour:
  - If `clear_req` = 1, no grant is issued this cycle and the FSM enters CLEAR with the clear counter at 0.
  - Otherwise, if exactly one port is valid, that port gets ready.
  - If both ports are valid, the port ≠ `last` gets ready.
- Ready is combinational from valid, `last` and state. A write is accepted when valid && ready in the same cycle.
- On an accepted write:
  - `buf[index] <= char`
  - `last <= granted port`
  - `wr_count` increments
- A requester holds valid/index/char stable until it sees ready. Dropping valid without ready is legal; nothing is written.
- CLEAR behaviour:
  - Each cycle writes 0x20 to cell `cnt` and increments `cnt`.
  - After `cnt` = 31 is written, the FSM returns to IDLE.
  - The sequence takes exactly 32 cycles.
  - Both readies are held at 0 and `clear_busy` = 1 throughout.
  - `clear_req` is ignored while in CLEAR.
  - `wr_count` does not count clear writes.
- Read path: `lcd_char <= buf[lcd_index]` every cycle.
- Same-cycle read and write to the same cell: `lcd_char` shows the old value; the new value appears one cycle later.
- Reset asserted mid-CLEAR or mid-handshake returns to IDLE with the full reset state; a partial clear is not resumed.

## Timing
- Grant latency: ready can assert in the same cycle valid rises, if the FSM is in IDLE and the port wins arbitration.
- Write-to-display: the cell is updated at the accepting edge. `lcd_char` reflects it one edge later, given the matching `lcd_index`.
- Read latency is 1 cycle from `lcd_index` to `lcd_char`.
- Fairness: with both ports continuously valid, grants alternate 0,1,0,1… Neither port waits more than 1 cycle in IDLE.
- Clear: the cycle after the `clear_req` edge is the first CLEAR write. `clear_busy` is high for 32 cycles. The first grant can occur in the cycle after `clear_busy` falls.

## Configuration
- `LCD_ARB_CLEAR_EN` defined:
  - The CLEAR state, the 5-bit clear counter and `clear_req` handling are compiled in, as described above.
- `LCD_ARB_CLEAR_EN` undefined:
  - The CLEAR state and counter are absent and `clear_req` is ignored.
  - `clear_busy` is tied 0.
  - The FSM is IDLE only.
  - All other behaviour is identical.

## Test plan
- Reset, then sweep `lcd_index` 0–31 → `lcd_char` = 0x20 for every cell; both readies 0; `wr_count` = 0.
- `req0` writes 0x41 to index 5, `req1` idle → `req0_ready` = 1 same cycle. With `lcd_index` = 5, `lcd_char` = 0x41 two edges after acceptance. `wr_count` = 1.
- Both ports valid for 4 cycles (port 0: index 0 'a'; port 1: index 16 'b') → grant order 0,1,0,1; `wr_count` = 4; cells 0 = 0x61, 16 = 0x62.
- With the macro: fill cells with 0x58, then pulse `clear_req` while `req0` is valid:
  - `req0_ready` stays 0 for the pulse cycle plus 32 cycles, and `clear_busy` is high for exactly 32 cycles.
  - All cells read 0x20 afterwards, then `req0` is granted.
- Assert `reset` on the 10th CLEAR cycle → next cycle `clear_busy` = 0, FSM in IDLE, all cells 0x20, `wr_count` = 0.
- Preload `wr_count` to 0xFFFF via 65535 accepted writes, then one more write → `wr_count` = 0x0000.
